// File: rtl/adc_timebase.sv
// ADC timebase: sequenced power-on reset, free-running 1 us tick, and a
// programmable ADC sample strobe with a wrapping strobe counter.
module adc_timebase #(
   parameter int CLK_HZ     = 48000000,
   parameter int POR_CYCLES = 4800,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic [DIV_WIDTH-1:0] sample_div,
   output logic                 sys_rst_n,
   output logic                 tick_1us,
   output logic                 sample_strobe,
   output logic [DIV_WIDTH-1:0] sample_count,
   output logic                 div_err
);

   localparam int TICK_DIV = CLK_HZ / 1000000;
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PW = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
   localparam logic [PW-1:0] POR_LAST = PW'(POR_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_WAIT,
      ST_ACTIVE
   } state_t;

   state_t               state_q;
   logic [PW-1:0]        por_cnt_q;
   logic [TW-1:0]        tick_cnt_q;
   logic [DIV_WIDTH-1:0] div_cnt_q;
   logic [DIV_WIDTH-1:0] div_q;
   logic [DIV_WIDTH-1:0] count_q;
   logic                 run_q;
   logic                 sys_rst_n_q;
   logic                 tick_q;
   logic                 strobe_q;
   logic                 div_err_q;

   logic                 div_small_d;
   logic [DIV_WIDTH-1:0] div_clamp_d;

   // Divisors below 2 are forced to 2 so the strobe never degenerates.
   always_comb begin
      div_small_d = (sample_div < DIV_WIDTH'(2));
      div_clamp_d = div_small_d ? DIV_WIDTH'(2) : sample_div;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register reads the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_HOLD;
         por_cnt_q   <= '0;
         tick_cnt_q  <= '0;
         div_cnt_q   <= '0;
         div_q       <= DIV_WIDTH'(2);
         count_q     <= '0;
         run_q       <= 1'b0;
         sys_rst_n_q <= 1'b0;
         tick_q      <= 1'b0;
         strobe_q    <= 1'b0;
         div_err_q   <= 1'b0;
      end else begin
         tick_q   <= 1'b0;
         strobe_q <= 1'b0;
         case (state_q)
            ST_HOLD: begin
               state_q   <= ST_WAIT;
               por_cnt_q <= '0;
            end
            ST_WAIT: begin
               if (por_cnt_q == POR_LAST) state_q <= ST_ACTIVE;
               else por_cnt_q <= por_cnt_q + PW'(1);
            end
            ST_ACTIVE: begin
               sys_rst_n_q <= 1'b1;
               run_q       <= run;
               // Tick counter starts once sys_rst_n is visible downstream.
               if (sys_rst_n_q) begin
                  if (tick_cnt_q == TICK_MAX) begin
                     tick_q     <= 1'b1;
                     tick_cnt_q <= '0;
                  end else begin
                     tick_cnt_q <= tick_cnt_q + TW'(1);
                  end
               end
               if (strobe_q) count_q <= count_q + DIV_WIDTH'(1);
               if (run && !run_q) begin
                  div_q     <= div_clamp_d;
                  div_err_q <= div_err_q | div_small_d;
                  div_cnt_q <= '0;
                  count_q   <= '0;
               end else if (!run) begin
                  div_cnt_q <= '0;
               end else if (div_cnt_q == div_q) begin
                  // Re-latch only at the period boundary: no mid-period glitch.
                  strobe_q  <= 1'b1;
                  div_cnt_q <= '0;
                  div_q     <= div_clamp_d;
                  div_err_q <= div_err_q | div_small_d;
               end else begin
                  div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
               end
            end
            default: state_q <= ST_HOLD;
         endcase
      end
   end

   assign sys_rst_n     = sys_rst_n_q;
   assign tick_1us      = tick_q;
   assign sample_strobe = strobe_q;
   assign sample_count  = count_q;
   assign div_err       = div_err_q;

endmodule

// File: doc/adc_timebase.md
Name: adc_timebase

Overview:
- Consumes the buffered 48 MHz global clock from the on-chip oscillator clock manager.
- Generates the design's sequenced system reset, a free-running 1 µs tick, and the programmable ADC sample strobe with a sample counter.
- Sits between the clock manager and the ADC capture/control logic; all downstream timing derives from its outputs.

Parameters:
- CLK_HZ, 48000000, input clock frequency in Hz; must be a multiple of 1000000.
- POR_CYCLES, 4800, clock cycles sys_rst_n is held low after reset deasserts (100 µs at 48 MHz); must be ≥ 1.
- DIV_WIDTH, 16, width of the sample divider and the sample counter.

Ports:
- clk  input  1  48 MHz system clock (buffered oscillator output).
- reset  input  1  synchronous, active-low reset.
- run  input  1  level; 1 enables sample strobe generation.
- sample_div  input  DIV_WIDTH  sample period minus one, in clk cycles.
- sys_rst_n  output  1  sequenced active-low reset for downstream logic.
- tick_1us  output  1  one-cycle pulse every CLK_HZ/1e6 cycles.
- sample_strobe  output  1  one-cycle ADC conversion start pulse.
- sample_count  output  DIV_WIDTH  number of strobes issued since run rose; wraps.
- div_err  output  1  sticky; sample_div < 2 was latched.

Behaviour:
- Reset: one clock, synchronous, active-low. While reset=0 at a clk edge, state←HOLD and all counters clear. sys_rst_n=0, tick_1us=0, sample_strobe=0, sample_count=0, div_err=0. Asserting reset mid-operation takes effect at that edge; no strobe is issued after it.
- FSM states: HOLD → WAIT → ACTIVE.
  - HOLD: entered on reset. Moves to WAIT on the first edge with reset=1.
  - WAIT: a POR counter increments each cycle. When it reaches POR_CYCLES-1, the FSM moves to ACTIVE. sys_rst_n rises exactly POR_CYCLES+1 edges after the first edge sampling reset=1.
  - ACTIVE: sys_rst_n=1. Only reset leaves this state.
- tick_1us:
  - Counter runs 0..CLK_HZ/1e6-1 (0..47), only in ACTIVE.
  - tick_1us=1 for the single cycle when the counter equals its max; the counter then wraps to 0.
  - First tick occurs 48 cycles after sys_rst_n rises; period is 48 cycles thereafter.
- Sample divider (ACTIVE only):
  - On the edge where run is first sampled 1 (run_q=0, run=1): latch D from sample_div, clear the divider counter, clear sample_count.
  - Clamp: if sample_div < 2, D←2 and div_err←1. div_err is sticky until reset.
  - The divider counts 0..D. sample_strobe=1 in the cycle the counter equals D; the counter then returns to 0.
  - First strobe occurs D+1 cycles after the latch edge; period is D+1 cycles.
  - sample_div is re-latched, with the same clamp, at each strobe cycle. A change therefore takes effect from the next period only; no mid-period glitch.
  - sample_count increments by 1 on each strobe, registered; it is visible the cycle after the strobe. It wraps from 2^DIV_WIDTH-1 to 0 with no flag.
  - run=0: the divider counter holds at 0 and sample_strobe=0. sample_count holds its value until the next run rise clears it.
  - run falling in the same cycle as a would-be strobe: no strobe is issued.
  - run=1 held through HOLD/WAIT: no strobes. A run rise is detected only in ACTIVE. If run is already 1 on entry to ACTIVE, that counts as a rise on the first ACTIVE edge.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- POR sequence (POR_CYCLES=16): reset=0 for 5 cycles, then 1 → sys_rst_n=0 for exactly 17 edges, then 1 permanently. tick_1us and sample_strobe stay 0 throughout.
- 1 µs tick: after sys_rst_n rises, run 2000 cycles → tick_1us pulses exactly every 48 cycles, each 1 cycle wide, first 48 cycles after release. 41 pulses total.
- Sample strobe: sample_div=9, run rises → strobe every 10 cycles, first 10 cycles after the rise. After 5 strobes, sample_count=5.
- Divider update and clamp:
  - Change sample_div 9→4 mid-period → the current period completes at 10 cycles, following periods are 5.
  - Then sample_div=0 → period 3 after the next strobe, div_err=1 and stays 1 after sample_div returns to 9.
- Run gating: run falls 3 cycles before the expected strobe → no strobe, sample_count holds. Run rises again → sample_count=0, first strobe D+1 cycles later.
- Reset mid-operation: sample_div=3, run=1, assert reset for 1 cycle during an active period → next edge shows all outputs 0, POR sequence restarts. No strobes until sys_rst_n returns and D+1 cycles elapse.
